// File: rtl/mac_accum_64_if.sv
// mac_accum_64_if: the product-input and result-output bus of mac_accum_64.
//   start/len            burst start request and burst length (sampled in IDLE)
//   prod_valid/ready     product stream handshake, product is the 64-bit data
//   res_valid/ready      result handshake, result is the 64-bit sum
//   overflow             sticky saturation flag for the burst
//   busy                 block is not idle
// slave  = the accumulator side, master = the driver/consumer side.
interface mac_accum_64_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             prod_valid;
  logic             prod_ready;
  logic [63:0]      product;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      result;
  logic             overflow;
  logic             busy;

  modport slave (
    input  start, len, prod_valid, product, res_ready,
    output prod_ready, res_valid, result, overflow, busy
  );

  modport master (
    output start, len, prod_valid, product, res_ready,
    input  prod_ready, res_valid, result, overflow, busy
  );
endinterface

// File: rtl/mac_accum_64.sv
// mac_accum_64: signed saturating multiply-accumulate back end.
// Sums a burst of len signed 64-bit products into a saturating 64-bit
// accumulator, then offers the sum (and a sticky overflow flag) on a
// valid/ready result port.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    mac_accum_64_if.slave (start/len, product stream, result, busy)
module mac_accum_64 #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_accum_64_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             ovf_q, ovf_d;

  logic [64:0]      sum_ext;
  logic             sat_hit;
  logic [63:0]      sat_val;

  // 65-bit sign-extended sum: bits 64 and 63 disagree exactly when the
  // true sum does not fit in 64 bits; bit 64 then gives the true sign.
  always_comb begin
    sum_ext = {acc_q[63], acc_q} + {bus.product[63], bus.product};
    sat_hit = sum_ext[64] ^ sum_ext[63];
    sat_val = sum_ext[63:0];
    if (sat_hit) begin
      sat_val = sum_ext[64] ? SAT_NEG : SAT_POS;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            remaining_d = bus.len;
            state_d     = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        // prod_ready is constantly high here, so prod_valid alone marks a transfer.
        if (bus.prod_valid) begin
          acc_d       = sat_val;
          ovf_d       = ovf_q | sat_hit;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs come straight from state/registers; result and overflow are
  // visible in every state and qualified only by res_valid.
  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.res_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.result     = acc_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_mac_accum_64.sv
module tb_mac_accum_64;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mac_accum_64_if #(.CNT_W(8)) bus ();

  mac_accum_64 #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       len;
    logic [3:0][63:0] prods;
    logic [63:0]      exp_result;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_burst(input logic [7:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][63:0] sp;
    logic [63:0]      exp_sum;
    int               idx;
    int               cyc;
    logic             v;
    logic             saw_valid;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{8'd3, {64'd0, 64'd7, -64'sd2, 64'd5}, 64'd10, 1'b0};
    vecs[1] = '{8'd0, {64'd0, 64'd0, 64'd0, 64'd0}, 64'd0, 1'b0};
    vecs[2] = '{8'd2, {64'd0, 64'd0, 64'h20, 64'h7FFF_FFFF_FFFF_FFF0}, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{8'd1, {64'd0, 64'd0, 64'd0, 64'd1}, 64'd1, 1'b0};
    vecs[4] = '{8'd3, {64'd0, 64'h10, -64'sd1, 64'h8000_0000_0000_0000}, 64'h8000_0000_0000_0010, 1'b1};
    vecs[5] = '{8'd4, {-64'sd1, 64'd2500, -64'sd3000, 64'd1000}, 64'd499, 1'b0};
    vecs[6] = '{8'd2, {64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000}, 64'h8000_0000_0000_0000, 1'b1};
    vecs[7] = '{8'd2, {64'd0, 64'd0, 64'd5, -64'sd5}, 64'd0, 1'b0};

    bus.start      = 1'b0;
    bus.len        = '0;
    bus.prod_valid = 1'b0;
    bus.product    = '0;
    bus.res_ready  = 1'b1;
    rst_n          = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_prod_ready", 64'(bus.prod_ready), 64'd0);
    chk("rst_res_valid",  64'(bus.res_valid),  64'd0);
    chk("rst_busy",       64'(bus.busy),       64'd0);
    chk("rst_result",     bus.result,          64'd0);
    chk("rst_overflow",   64'(bus.overflow),   64'd0);
    rst_n = 1'b1;

    // Table-driven back-to-back bursts
    for (int t = 0; t < 8; t++) begin
      start_burst(vecs[t].len);
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      for (int i = 0; i < int'(vecs[t].len); i++) begin
        chk("prod_ready_accum", 64'(bus.prod_ready), 64'd1);
        chk("res_valid_early",  64'(bus.res_valid),  64'd0);
        bus.prod_valid = 1'b1;
        bus.product    = vecs[t].prods[i];
        @(negedge clk);
      end
      bus.prod_valid = 1'b0;
      bus.product    = '0;
      chk("res_valid_latency", 64'(bus.res_valid),  64'd1);
      chk("prod_ready_done",   64'(bus.prod_ready), 64'd0);
      chk("result",            bus.result,          vecs[t].exp_result);
      chk("overflow",          64'(bus.overflow),   64'(vecs[t].exp_ovf));
      $display("[TB] burst %0d len=%0d result=%h overflow=%b", t, vecs[t].len, bus.result, bus.overflow);
      @(negedge clk);
      chk("busy_after_result", 64'(bus.busy),      64'd0);
      chk("res_valid_cleared", 64'(bus.res_valid), 64'd0);
    end

    // Handshake stalls: random prod_valid, start pulses while busy, result stall
    sp = {64'd1000, 64'd20, -64'sd8, 64'd3};
    bus.res_ready = 1'b0;
    start_burst(8'd4);
    bus.len = 8'd1;
    idx = 0;
    exp_sum = '0;
    cyc = 0;
    while (idx < 4 && cyc < 80) begin
      v = 1'($urandom_range(0, 1));
      bus.start = 1'($urandom_range(0, 1));
      bus.prod_valid = v;
      bus.product    = v ? sp[idx] : 64'hDEAD_BEEF_0BAD_F00D;
      if (v && bus.prod_ready) begin
        exp_sum = exp_sum + sp[idx];
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stall_all_accepted", 64'(idx), 64'd4);
    bus.prod_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_res_valid", 64'(bus.res_valid), 64'd1);
      chk("stall_result",    bus.result,         exp_sum);
      chk("stall_overflow",  64'(bus.overflow),  64'd0);
      bus.start = k[0];
      @(negedge clk);
    end
    $display("[TB] stall burst len=4 result=%h overflow=%b", bus.result, bus.overflow);
    // start held high through the DONE->IDLE handoff cycle must be ignored
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("handoff_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("handoff_start_ignored", 64'(bus.busy), 64'd0);

    // Reset mid-burst
    start_burst(8'd4);
    bus.prod_valid = 1'b1;
    bus.product    = 64'd100;
    @(negedge clk);
    bus.product    = 64'd200;
    @(negedge clk);
    bus.prod_valid = 1'b0;
    chk("midburst_acc_nonzero", 64'(bus.result != 64'd0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_prod_ready", 64'(bus.prod_ready), 64'd0);
    chk("midrst_res_valid",  64'(bus.res_valid),  64'd0);
    chk("midrst_busy",       64'(bus.busy),       64'd0);
    chk("midrst_result",     bus.result,          64'd0);
    chk("midrst_overflow",   64'(bus.overflow),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.res_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_result", 64'(saw_valid), 64'd0);
    start_burst(8'd1);
    bus.prod_valid = 1'b1;
    bus.product    = 64'd9;
    @(negedge clk);
    bus.prod_valid = 1'b0;
    chk("post_rst_res_valid", 64'(bus.res_valid), 64'd1);
    chk("post_rst_result",    bus.result,         64'd9);
    chk("post_rst_overflow",  64'(bus.overflow),  64'd0);
    $display("[TB] post-reset burst len=1 result=%h overflow=%b", bus.result, bus.overflow);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accum_64.md
# mac_accum_64

Signed multiply-accumulate back end placed directly downstream of the 32x32 signed Wallace multiplier. Accepts a programmable-length burst of 64-bit signed products over a valid/ready handshake and sums them into a 64-bit saturating accumulator. Presents the final sum, with a sticky overflow flag, on a second valid/ready output. Turns the combinational multiplier into a dot-product unit for the ALU.

## Interface

Parameters:
- CNT_W, default 8: width of the burst-length field; maximum burst is 2^CNT_W − 1 products.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a burst; sampled only in IDLE
- len  input  CNT_W  number of products in the burst; sampled with start
- prod_valid  input  1  product word valid
- prod_ready  output  1  block accepts a product this cycle
- product  input  64  signed two's-complement product from the multiplier
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- result  output  64  signed accumulated sum
- overflow  output  1  sticky flag; saturation occurred during this burst
- busy  output  1  high in any state other than IDLE

## Operation

- States: IDLE, ACCUM, DONE. Registers: acc[63:0], remaining[CNT_W-1:0], ovf.
- IDLE: prod_ready=0, res_valid=0, busy=0.
  - start=1, len≠0: acc←0, ovf←0, remaining←len; go to ACCUM.
  - start=1, len=0: acc←0, ovf←0; go directly to DONE.
  - start=0: stay in IDLE.
- ACCUM: prod_ready=1. A transfer occurs when prod_valid and prod_ready are both high.
  - On a transfer: acc←sat(acc+product), remaining←remaining−1.
  - If remaining was 1 at the transfer: go to DONE.
  - No transfer: hold all state.
- DONE: res_valid=1, result=acc, overflow=ovf, prod_ready=0.
  - res_ready=1: go to IDLE.
  - res_ready=0: result and overflow hold stable.
- start is ignored outside IDLE, including start asserted during the DONE→IDLE handoff cycle.
- Saturating addition:
  - Compute a 65-bit sign-extended sum.
  - If bits 64 and 63 differ: clamp to 0x7FFF_FFFF_FFFF_FFFF when bit 64=0, or to 0x8000_0000_0000_0000 when bit 64=1, and set ovf←1.
  - ovf stays set until the next start.
  - Later products add to the clamped value, so a burst can leave saturation again while overflow remains 1.
- result and overflow are driven directly from registers in every state. They are qualified only by res_valid.

## Timing

- Reset (asynchronous assert, synchronous deassert externally):
  - state=IDLE; acc, remaining, ovf = 0.
  - prod_ready=0, res_valid=0, busy=0, result=0, overflow=0.
- Reset asserted mid-burst or in DONE discards the burst immediately. No result is emitted.
- prod_ready rises on the cycle after start is accepted.
- One product is accepted per cycle maximum. A burst of N back-to-back products takes N cycles in ACCUM.
- res_valid rises on the cycle after the last product transfer. Latency from the final product to the result is 1 cycle.
- len=0: res_valid rises 1 cycle after start, with result=0.
- Minimum turnaround is start → … → DONE → IDLE → next start accepted in IDLE. That is one idle cycle after the res_valid/res_ready handshake.
- prod_valid gaps stall ACCUM indefinitely with no timeout.
- res_ready low stalls DONE indefinitely.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Test plan

- Reset and basic burst:
  - Stimulus: reset, then start with len=3; products 5, −2, 7 back-to-back; res_ready=1.
  - Required: result=10, overflow=0; res_valid high exactly 1 cycle after the third transfer; busy low afterwards.
- Zero length:
  - Stimulus: start with len=0.
  - Required: res_valid next cycle; result=0, overflow=0; prod_ready never asserts.
- Positive saturation:
  - Stimulus: len=2; products 0x7FFF_FFFF_FFFF_FFF0 and 0x20.
  - Required: result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
  - Then start len=1 with product 1: overflow=0, result=1.
- Saturation then recovery:
  - Stimulus: len=3; products 0x8000_0000_0000_0000, −1, 0x10.
  - Required: result=0x8000_0000_0000_0010, overflow=1.
- Handshake stalls:
  - Stimulus: len=4 with prod_valid toggled randomly; res_ready held low 5 cycles.
  - Required: sum counts only accepted words; result stable throughout the stall; start pulses during busy are ignored.
- Reset mid-burst:
  - Stimulus: assert rst_n low after 2 of 4 products.
  - Required: all outputs 0 immediately; no res_valid.
  - A new len=1 burst with product 9 then yields result=9.
